// File: rtl/uart_tx_dev_if.sv
// -----------------------------------------------------------------------------
// uart_tx_dev_if
//   Device-bus bundle between the Bridge and the UART transmitter.
//
//   Addr : word offset (0=TXDATA, 1=STATUS, 2=DIVISOR, 3=CTRL)
//   WD   : write data
//   WE   : write enable, already qualified by the Bridge device select
//   RD   : read data, combinational from Addr
//
//   master : Bridge / CPU side (drives Addr, WD, WE; receives RD)
//   slave  : peripheral side  (receives Addr, WD, WE; drives RD)
// -----------------------------------------------------------------------------
interface uart_tx_dev_if;
   logic [1:0]  Addr;
   logic [31:0] WD;
   logic        WE;
   logic [31:0] RD;

   modport master (output Addr, output WD, output WE, input RD);
   modport slave  (input Addr, input WD, input WE, output RD);
endinterface

// File: rtl/uart_tx_dev.sv
// -----------------------------------------------------------------------------
// uart_tx_dev
//   Bus-responder UART transmitter. The CPU pushes bytes into a TX FIFO
//   through the device bus; a baud-rate serializer drains the FIFO and emits
//   8N1 frames (LSB first) on txd. A level interrupt reports "transmitter
//   idle and FIFO empty" when enabled.
//
//   Ports
//     clk    : device clock
//     reset  : synchronous, active-high
//     bus    : uart_tx_dev_if.slave (Addr, WD, WE in; RD out)
//     txd    : serial output, idles high
//     IRQ    : registered level interrupt
//
//   Register map (word offsets)
//     0 TXDATA  : write pushes WD[7:0]; reads 0
//     1 STATUS  : {count[3:0], overflow, empty, full, busy}; any write
//                 clears overflow
//     2 DIVISOR : clk cycles per bit, WD[15:0]; 0 behaves as 1
//     3 CTRL    : bit0 = interrupt enable
// -----------------------------------------------------------------------------
module uart_tx_dev #(
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_RESET  = 217
) (
   input  logic         clk,
   input  logic         reset,
   uart_tx_dev_if.slave bus,
   output logic         txd,
   output logic         IRQ
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] ADDR_TXDATA  = 2'd0;
   localparam logic [1:0] ADDR_STATUS  = 2'd1;
   localparam logic [1:0] ADDR_DIVISOR = 2'd2;
   localparam logic [1:0] ADDR_CTRL    = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_e;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_e             state_q;
   logic [15:0]        timer_q;
   logic [2:0]         bit_idx_q;
   logic [7:0]         shift_q;
   logic [15:0]        div_q;
   logic               txd_q;
   logic               irq_q;

   logic [15:0]        divisor_q, divisor_d;
   logic               ie_q, ie_d;
   logic               ovf_q, ovf_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [7:0]         mem [FIFO_DEPTH];

   // ---------------------------------------------------------------------------
   // Bus decode and FIFO control
   // ---------------------------------------------------------------------------
   logic        wr_txdata;
   logic        empty, full;
   logic        push, pop;
   logic        bit_end;
   logic        busy;
   logic        irq_d;
   logic [15:0] eff_div;
   logic [7:0]  head;
   logic [4:0]  cnt_ext;
   logic        unused_wd;

   // Only the low half of WD carries register data.
   assign unused_wd = ^bus.WD[31:16];

   assign wr_txdata = bus.WE && (bus.Addr == ADDR_TXDATA);
   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_W'(FIFO_DEPTH));
   // Acceptance is judged on the pre-edge count, so a same-cycle pop never
   // rescues a write that arrives while full.
   assign push      = wr_txdata && !full;
   assign bit_end   = (timer_q == '0);
   assign busy      = (state_q != S_IDLE);
   assign eff_div   = (divisor_q == '0) ? 16'd1 : divisor_q;
   assign head      = mem[rd_ptr_q];
   assign cnt_ext   = 5'(count_q);

   // The serializer pops from IDLE, or on the final STOP cycle to chain the
   // next frame without an idle gap.
   assign pop = !empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));

   // NOTE: every signal assigned in an always_comb gets a default first so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push && pop) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_comb begin
      divisor_d = divisor_q;
      ie_d      = ie_q;
      ovf_d     = ovf_q;
      if (bus.WE) begin
         case (bus.Addr)
            ADDR_TXDATA:  if (full) ovf_d = 1'b1;
            ADDR_STATUS:  ovf_d = 1'b0;
            ADDR_DIVISOR: divisor_d = bus.WD[15:0];
            ADDR_CTRL:    ie_d = bus.WD[0];
            default:      ;
         endcase
      end
   end

   // Uses the enable value taking effect at this edge so that setting or
   // clearing ie is visible on IRQ right after the write.
   assign irq_d = ie_d && empty && (state_q == S_IDLE) && !push;

   // ---------------------------------------------------------------------------
   // Read mux: combinational, reflects register state before the current edge
   // ---------------------------------------------------------------------------
   always_comb begin
      bus.RD = '0;
      case (bus.Addr)
         ADDR_STATUS:  bus.RD = {24'b0, cnt_ext[3:0], ovf_q, empty, full, busy};
         ADDR_DIVISOR: bus.RD = {16'b0, divisor_q};
         ADDR_CTRL:    bus.RD = {31'b0, ie_q};
         default:      bus.RD = '0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Control/status registers and FIFO pointers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         divisor_q <= 16'(DIV_RESET);
         ie_q      <= 1'b0;
         ovf_q     <= 1'b0;
         count_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         irq_q     <= 1'b0;
      end else begin
         divisor_q <= divisor_d;
         ie_q      <= ie_d;
         ovf_q     <= ovf_d;
         count_q   <= count_d;
         irq_q     <= irq_d;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
   end

   // NOTE: the FIFO storage is deliberately not reset; the pointers and count
   // define which entries are valid, so clearing the array buys nothing.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= bus.WD[7:0];
   end

   // ---------------------------------------------------------------------------
   // Serializer FSM with registered txd
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         txd_q     <= 1'b1;
         timer_q   <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         div_q     <= 16'(DIV_RESET);
      end else begin
         case (state_q)
            S_IDLE: begin
               txd_q <= 1'b1;
               if (pop) begin
                  // Divisor is latched per frame; later writes wait for the
                  // next frame.
                  shift_q <= head;
                  div_q   <= eff_div;
                  timer_q <= eff_div - 16'd1;
                  txd_q   <= 1'b0;
                  state_q <= S_START;
               end
            end

            S_START: begin
               if (bit_end) begin
                  state_q   <= S_DATA;
                  bit_idx_q <= '0;
                  txd_q     <= shift_q[0];
                  timer_q   <= div_q - 16'd1;
               end else begin
                  timer_q <= timer_q - 16'd1;
               end
            end

            S_DATA: begin
               if (bit_end) begin
                  timer_q <= div_q - 16'd1;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= S_STOP;
                     txd_q   <= 1'b1;
                  end else begin
                     // txd already shows shift_q[0]; advance to the next bit.
                     bit_idx_q <= bit_idx_q + 3'd1;
                     shift_q   <= shift_q >> 1;
                     txd_q     <= shift_q[1];
                  end
               end else begin
                  timer_q <= timer_q - 16'd1;
               end
            end

            S_STOP: begin
               if (bit_end) begin
                  if (pop) begin
                     shift_q <= head;
                     div_q   <= eff_div;
                     timer_q <= eff_div - 16'd1;
                     txd_q   <= 1'b0;
                     state_q <= S_START;
                  end else begin
                     txd_q   <= 1'b1;
                     state_q <= S_IDLE;
                  end
               end else begin
                  timer_q <= timer_q - 16'd1;
               end
            end

            default: begin
               txd_q   <= 1'b1;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign txd = txd_q;
   assign IRQ = irq_q;

endmodule
